dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory that answers RISC-V style
// load/store requests with a fixed two-cycle request-to-response latency.
//
// Ports
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset (storage is not reset)
//   req_valid  core presents a request          req_ready  high only in IDLE
//   req_we     1 = store, 0 = load              req_func3  RISC-V width code
//   req_addr   byte address                     req_wdata  right-aligned store data
//   rsp_valid  response available (RESP)        rsp_ready  core takes response
//   rsp_rdata  extended load data, 0 otherwise  rsp_err    misaligned / illegal func3
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic            we_q;
  logic [2:0]      func3_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic            req_err;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rd_word;
  logic [3:0]      byte_en;
  logic [31:0]     wr_data;
  logic [31:0]     load_data;

  // Address bits above the storage range are deliberately dropped (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW];

  // Error decode is done at accept time so the FSM only carries one flag.
  always_comb begin
    req_err = 1'b0;
    case (req_func3)
      3'b000:        req_err = 1'b0;
      3'b001:        req_err = req_addr[0];
      3'b010:        req_err = (req_addr[1:0] != 2'b00);
      3'b100:        req_err = req_we;
      3'b101:        req_err = req_we | req_addr[0];
      default:       req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      func3_q <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            func3_q <= req_func3;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            state   <= ACCESS;
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-lane write enables and lane data: byte data is replicated to every
  // lane, halfword data to both halves, so each lane picks a fixed slice.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (func3_q[1:0])
          2'b00: begin
            byte_en[gi]          = (addr_q[1:0] == 2'(gi));
            wr_data[gi*8 +: 8]   = wdata_q[7:0];
          end
          2'b01: begin
            byte_en[gi]          = (addr_q[1] == 1'((gi >> 1) & 1));
            wr_data[gi*8 +: 8]   = wdata_q[(gi%2)*8 +: 8];
          end
          default: begin
            byte_en[gi]          = 1'b1;
            wr_data[gi*8 +: 8]   = wdata_q[gi*8 +: 8];
          end
        endcase
      end
    end
  endgenerate

  // Storage: read and write happen on the ACCESS edge. An asynchronous reset
  // during ACCESS has already pulled state to IDLE, so no write can follow.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      rd_word <= mem[addr_q[AW-1:2]];
      if (we_q && !err_q) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[addr_q[AW-1:2]][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Lane select and sign/zero extension of the registered read word.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] sb;
    logic [31:0] sh;
    sb = rd_word >> {addr_q[1:0], 3'b000};
    sh = rd_word >> {addr_q[1], 4'b0000};
    b  = sb[7:0];
    h  = sh[15:0];
    case (func3_q[1:0])
      2'b00:   load_data = {{24{b[7] & ~func3_q[2]}}, b};
      2'b01:   load_data = {{16{h[15] & ~func3_q[2]}}, h};
      default: load_data = rd_word;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = ((state == RESP) && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with a byte-array
// reference model, plus directed cases for alignment, wrap, stall and reset.
module tb_dmem_responder;

  localparam int DL    = 8;
  localparam int BYTES = 4 << DL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mref [BYTES];

  dmem_responder #(.DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses as byte sequences.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int a;
    int sz;
    a     = int'(addr % BYTES);
    sz    = 1 << f3[1:0];
    rdata = 32'h0;
    if (we) err = (f3 > 3'd2);
    else    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (!err && (a % sz) != 0) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int i = 0; i < sz; i++) mref[a + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < sz; i++) rdata = rdata | (32'(mref[a + i]) << (8 * i));
      if (!f3[2] && sz < 4 && rdata[8*sz-1]) rdata = rdata | (32'hFFFF_FFFF << (8 * sz));
    end
  endtask

  // One complete transaction; hold = extra RESP cycles with rsp_ready low.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] got_d, output logic got_e);
    logic        e;
    logic [31:0] d;
    ref_access(we, f3, addr, wdata, e, d);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));  // must be ignored during ACCESS
    @(negedge clk);
    chk("rsp_valid_access", 32'(rsp_valid), 32'd0);
    chk("req_ready_access", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_resp", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, d);
    chk("rsp_err", 32'(rsp_err), 32'(e));
    got_d = rsp_rdata;
    got_e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'($urandom); req_addr = $urandom; req_func3 = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, d);
      chk("hold_err", 32'(rsp_err), 32'(e));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    $display("txn we=%0d f3=%0d addr=%h wdata=%h hold=%0d -> rdata=%h err=%0d (exp %h/%0d)",
             we, f3, addr, wdata, hold, got_d, got_e, d, e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_err"},   32'(rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value so random loads are predictable.
    for (int w = 0; w < (1 << DL); w++) txn(1'b1, 3'b010, 32'(w * 4), $urandom, 0, d, e);

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, d, e);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, d, e);   chk("lw_10", d, 32'hDEADBEEF);
    txn(1'b1, 3'b000, 32'h11, 32'h7F, 0, d, e);  chk("sb_rdata", d, 32'h0);
    txn(1'b0, 3'b000, 32'h11, 32'h0, 0, d, e);   chk("lb_11", d, 32'h0000007F);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, d, e);   chk("lw_10_merged", d, 32'hDEAD7FEF);
    txn(1'b0, 3'b100, 32'h13, 32'h0, 0, d, e);   chk("lbu_13", d, 32'h000000DE);
    txn(1'b0, 3'b000, 32'h13, 32'h0, 0, d, e);   chk("lb_13", d, 32'hFFFFFFDE);
    txn(1'b0, 3'b001, 32'h12, 32'h0, 0, d, e);   chk("lh_12", d, 32'hFFFFDEAD);
    txn(1'b0, 3'b101, 32'h12, 32'h0, 0, d, e);   chk("lhu_12", d, 32'h0000DEAD);
    txn(1'b0, 3'b001, 32'h13, 32'h0, 0, d, e);   chk("lh_13_err", 32'(e), 32'd1);
    chk("lh_13_rdata", d, 32'h0);
    txn(1'b0, 3'b010, 32'h14, 32'h0, 0, d, e);   a = d;
    txn(1'b1, 3'b010, 32'h16, 32'h12345678, 0, d, e); chk("sw_16_err", 32'(e), 32'd1);
    txn(1'b0, 3'b010, 32'h14, 32'h0, 0, d, e);   chk("lw_14_kept", d, a);
    txn(1'b0, 3'b011, 32'h10, 32'h0, 0, d, e);   chk("ld_f3_011_err", 32'(e), 32'd1);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 5, d, e);   chk("lw_hold", d, 32'hDEAD7FEF);
    txn(1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 0, d, e);
    txn(1'b0, 3'b010, 32'h0, 32'h0, 0, d, e);    chk("lw_wrap", d, 32'hA5A5A5A5);

    // Reset during ACCESS of a store: no write, outputs reset at once.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_access");
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 3'b010, 32'h20, 32'h0, 0, d, e);
    $display("reset-in-access load addr=00000020 -> rdata=%h", d);

    // Reset while a response is pending: response dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_resp_pre_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_resp");
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset-in-resp response discarded");

    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      txn(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3), d, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
